// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit and its extension stage.
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2,
        RSVD = 2'd3
    } width_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        SPLIT  = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    function automatic logic [2:0] bytes_of(width_e w);
        case (w)
            BYTE:    return 3'd1;
            HALF:    return 3'd2;
            WORD:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic is_aligned(logic [1:0] addr_lo, width_e w);
        case (w)
            BYTE:    return 1'b1;
            HALF:    return ~addr_lo[0];
            WORD:    return (addr_lo == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Zero/sign extension of a byte or half value to XLEN; words pass through.
module lsu_extend import lsu_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_data,
    input  logic [1:0]      i_width,
    input  logic            i_sign_extend,
    output logic [XLEN-1:0] o_data
);

    // Replicate the top bit of the accessed field when sign extension is requested.
    always_comb begin
        o_data = i_data;
        case (width_e'(i_width))
            BYTE:    o_data = {{(XLEN-8){i_sign_extend & i_data[7]}}, i_data[7:0]};
            HALF:    o_data = {{(XLEN-16){i_sign_extend & i_data[15]}}, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store master for the unified data memory port.
// MISALIGN_SPLIT_EN builds byte-beat splitting of misaligned accesses; otherwise they fault.
module load_store_unit import lsu_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_width,
    input  logic            req_sign_extend,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [1:0]      mem_width,
    output logic            mem_sign_extend,
    output logic            mem_read_en,
    output logic            mem_write_en,
    input  logic [XLEN-1:0] mem_valM,
    input  logic            mem_fault
);

    lsu_state_e      r_state;
    logic            r_req_ready, r_resp_valid, r_resp_fault;
    logic            r_mem_read_en, r_mem_write_en, r_write, r_sext;
    logic [XLEN-1:0] r_resp_data, r_mem_addr, r_mem_wdata;
    logic [1:0]      r_mem_width;
    width_e          r_width;
    width_e          w_req_width;
    logic [XLEN-1:0] w_ext_in, w_ext_out;
`ifdef MISALIGN_SPLIT_EN
    logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
    logic [1:0]      r_beat, w_next_beat;
    logic            w_last_beat;

    assign w_next_beat = r_beat + 2'd1;
    assign w_last_beat = ({1'b0, r_beat} == (bytes_of(r_width) - 3'd1));
`endif

    assign w_req_width     = width_e'(req_width);
    assign mem_sign_extend = 1'b0;

    // Split loads extend the assembled bytes with the current beat merged in.
    always_comb begin
        w_ext_in = mem_valM;
`ifdef MISALIGN_SPLIT_EN
        if (r_state == SPLIT) begin
            w_ext_in = r_rdata;
            w_ext_in[{r_beat, 3'b000} +: 8] = mem_valM[7:0];
        end else begin
            w_ext_in = mem_valM;
        end
`endif
    end

    lsu_extend #(.XLEN(XLEN)) u_extend (
        .i_data        (w_ext_in),
        .i_width       (r_width),
        .i_sign_extend (r_sext),
        .o_data        (w_ext_out)
    );

    // Transaction FSM; every port-facing output is a register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_req_ready    <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_resp_data    <= {XLEN{1'b0}};
            r_resp_fault   <= 1'b0;
            r_mem_addr     <= {XLEN{1'b0}};
            r_mem_wdata    <= {XLEN{1'b0}};
            r_mem_width    <= 2'd0;
            r_mem_read_en  <= 1'b0;
            r_mem_write_en <= 1'b0;
            r_write        <= 1'b0;
            r_sext         <= 1'b0;
            r_width        <= BYTE;
`ifdef MISALIGN_SPLIT_EN
            r_addr         <= {XLEN{1'b0}};
            r_wdata        <= {XLEN{1'b0}};
            r_rdata        <= {XLEN{1'b0}};
            r_beat         <= 2'd0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_write     <= req_write;
                        r_sext      <= req_sign_extend;
                        r_width     <= w_req_width;
`ifdef MISALIGN_SPLIT_EN
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
`endif
                        if (w_req_width == RSVD) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                            r_resp_data  <= {XLEN{1'b0}};
                        end else if (is_aligned(req_addr[1:0], w_req_width)) begin
                            r_state        <= ACCESS;
                            r_mem_addr     <= req_addr;
                            r_mem_wdata    <= req_wdata;
                            r_mem_width    <= req_width;
                            r_mem_read_en  <= ~req_write;
                            r_mem_write_en <= req_write;
                        end else begin
`ifdef MISALIGN_SPLIT_EN
                            r_state        <= SPLIT;
                            r_beat         <= 2'd0;
                            r_rdata        <= {XLEN{1'b0}};
                            r_mem_addr     <= req_addr;
                            r_mem_wdata    <= {{(XLEN-8){1'b0}}, req_wdata[7:0]};
                            r_mem_width    <= 2'd0;
                            r_mem_read_en  <= ~req_write;
                            r_mem_write_en <= req_write;
`else
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                            r_resp_data  <= {XLEN{1'b0}};
`endif
                        end
                    end
                end
                ACCESS: begin
                    r_mem_read_en  <= 1'b0;
                    r_mem_write_en <= 1'b0;
                    r_state        <= RESP;
                    r_resp_valid   <= 1'b1;
                    r_resp_fault   <= mem_fault;
                    r_resp_data    <= (mem_fault | r_write) ? {XLEN{1'b0}} : w_ext_out;
                end
`ifdef MISALIGN_SPLIT_EN
                SPLIT: begin
                    if (mem_fault || w_last_beat) begin
                        r_mem_read_en  <= 1'b0;
                        r_mem_write_en <= 1'b0;
                        r_state        <= RESP;
                        r_resp_valid   <= 1'b1;
                        r_resp_fault   <= mem_fault;
                        r_resp_data    <= (mem_fault | r_write) ? {XLEN{1'b0}} : w_ext_out;
                    end else begin
                        r_beat      <= w_next_beat;
                        r_rdata     <= w_ext_in;
                        r_mem_addr  <= r_addr + {{(XLEN-2){1'b0}}, w_next_beat};
                        r_mem_wdata <= {{(XLEN-8){1'b0}}, r_wdata[{w_next_beat, 3'b000} +: 8]};
                    end
                end
`endif
                RESP: begin
                    if (resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_fault <= 1'b0;
                        r_resp_data  <= {XLEN{1'b0}};
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_req_ready    <= 1'b1;
                    r_resp_valid   <= 1'b0;
                    r_mem_read_en  <= 1'b0;
                    r_mem_write_en <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_data    = r_resp_data;
    assign resp_fault   = r_resp_fault;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_width    = r_mem_width;
    assign mem_read_en  = r_mem_read_en;
    assign mem_write_en = r_mem_write_en;

endmodule
